// File: rtl/cache_tag_ctrl_if.sv
// Bundled request, response, LRU and error signals for cache_tag_ctrl.
// The slave modport is the controller side; the master modport is the environment side.
interface cache_tag_ctrl_if #(
    parameter int NUM_WAYS = 4,
    parameter int TAG_W    = 8
);
    localparam int WL = $clog2(NUM_WAYS);

    logic                req_valid_i;
    logic                req_ready_o;
    logic [1:0]          req_op_i;
    logic [TAG_W-1:0]    req_tag_i;

    logic                rsp_valid_o;
    logic                rsp_ready_i;
    logic                rsp_hit_o;
    logic [WL-1:0]       rsp_way_o;
    logic                rsp_evict_o;
    logic [TAG_W-1:0]    rsp_evict_tag_o;

    logic                ls_valid_o;
    logic [1:0]          ls_op_o;
    logic [WL-1:0]       ls_way_o;
    logic                lru_valid_i;
    logic [NUM_WAYS-1:0] lru_way_i;

    logic                err_o;

    modport slave (
        input  req_valid_i, req_op_i, req_tag_i, rsp_ready_i, lru_valid_i, lru_way_i,
        output req_ready_o, rsp_valid_o, rsp_hit_o, rsp_way_o, rsp_evict_o, rsp_evict_tag_o,
        output ls_valid_o, ls_op_o, ls_way_o, err_o
    );

    modport master (
        output req_valid_i, req_op_i, req_tag_i, rsp_ready_i, lru_valid_i, lru_way_i,
        input  req_ready_o, rsp_valid_o, rsp_hit_o, rsp_way_o, rsp_evict_o, rsp_evict_tag_o,
        input  ls_valid_o, ls_op_o, ls_way_o, err_o
    );
endinterface

// File: rtl/cache_tag_ctrl.sv
// Single-set tag controller driving the LRU load/store/invalidate interface.
// Optional macro CACHE_TAG_CTRL_CHECK_EN builds the sticky err_o check on the LRU victim.
module cache_tag_ctrl #(
    parameter int NUM_WAYS = 4,
    parameter int TAG_W    = 8
) (
    input logic              clk,
    input logic              reset,
    cache_tag_ctrl_if.slave  bus
);
    localparam int WL = $clog2(NUM_WAYS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMP  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] OP_LOOKUP = 2'b01;
    localparam logic [1:0] OP_INVAL  = 2'b11;

    localparam logic [1:0] LS_LOAD  = 2'b01;
    localparam logic [1:0] LS_STORE = 2'b10;
    localparam logic [1:0] LS_INVAL = 2'b11;

    logic [1:0]          state;
    logic [TAG_W-1:0]    tag_q [NUM_WAYS];
    logic [NUM_WAYS-1:0] vld_q;
    logic [1:0]          op_q;
    logic [TAG_W-1:0]    tag_lat;

    logic                rsp_hit_q;
    logic [WL-1:0]       rsp_way_q;
    logic                rsp_evict_q;
    logic [TAG_W-1:0]    rsp_evict_tag_q;

    logic [NUM_WAYS-1:0] hit_vec;
    logic                hit_any;
    logic [WL-1:0]       hit_way;
    logic [WL-1:0]       victim;
    logic                in_cmp;
    logic                is_lookup;
    logic                is_inval;

    logic                ls_valid;
    logic [1:0]          ls_op;
    logic [WL-1:0]       ls_way;

    assign in_cmp    = (state == S_CMP);
    assign is_lookup = (op_q == OP_LOOKUP);
    assign is_inval  = (op_q == OP_INVAL);

    // Tags stay unique because fills only happen on a miss, so the hit vector is at most one-hot.
    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            hit_vec[i] = vld_q[i] && (tag_q[i] == tag_lat);
            if (hit_vec[i]) begin
                hit_way = WL'(i);
            end
        end
        hit_any = |hit_vec;
    end

    always_comb begin
        victim = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (bus.lru_way_i[i]) begin
                victim = WL'(i);
            end
        end
    end

    always_comb begin
        ls_valid = 1'b0;
        ls_op    = 2'b00;
        ls_way   = '0;
        if (in_cmp) begin
            if (is_lookup) begin
                ls_valid = 1'b1;
                if (hit_any) begin
                    ls_op  = LS_LOAD;
                    ls_way = hit_way;
                end else begin
                    ls_op  = LS_STORE;
                end
            end else if (is_inval && hit_any) begin
                ls_valid = 1'b1;
                ls_op    = LS_INVAL;
                ls_way   = hit_way;
            end
        end
    end

    // Reset in CMP or RESP drops the pending request and clears every valid bit alongside the LRU.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            vld_q           <= '0;
            op_q            <= 2'b00;
            tag_lat         <= '0;
            rsp_hit_q       <= 1'b0;
            rsp_way_q       <= '0;
            rsp_evict_q     <= 1'b0;
            rsp_evict_tag_q <= '0;
            for (int i = 0; i < NUM_WAYS; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid_i) begin
                        op_q    <= bus.req_op_i;
                        tag_lat <= bus.req_tag_i;
                        state   <= S_CMP;
                    end
                end
                S_CMP: begin
                    state           <= S_RESP;
                    rsp_hit_q       <= 1'b0;
                    rsp_way_q       <= '0;
                    rsp_evict_q     <= 1'b0;
                    rsp_evict_tag_q <= '0;
                    if (is_lookup) begin
                        if (hit_any) begin
                            rsp_hit_q <= 1'b1;
                            rsp_way_q <= hit_way;
                        end else begin
                            rsp_way_q       <= victim;
                            rsp_evict_q     <= vld_q[victim];
                            rsp_evict_tag_q <= tag_q[victim];
                            tag_q[victim]   <= tag_lat;
                            vld_q[victim]   <= 1'b1;
                        end
                    end else if (is_inval && hit_any) begin
                        rsp_hit_q      <= 1'b1;
                        rsp_way_q      <= hit_way;
                        vld_q[hit_way] <= 1'b0;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready_i) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CACHE_TAG_CTRL_CHECK_EN
    logic err_q;
    logic lru_bad;

    // The LRU must hand back exactly one valid victim whenever a store is issued.
    assign lru_bad = !bus.lru_valid_i
                  || (bus.lru_way_i == '0)
                  || ((bus.lru_way_i & (bus.lru_way_i - {{(NUM_WAYS-1){1'b0}}, 1'b1})) != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (in_cmp && is_lookup && !hit_any && lru_bad) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err_o = err_q;
`else
    logic unused_lru_valid;

    assign unused_lru_valid = bus.lru_valid_i;
    assign bus.err_o        = 1'b0;
`endif

    assign bus.req_ready_o     = (state == S_IDLE);
    assign bus.rsp_valid_o     = (state == S_RESP);
    assign bus.rsp_hit_o       = rsp_hit_q;
    assign bus.rsp_way_o       = rsp_way_q;
    assign bus.rsp_evict_o     = rsp_evict_q;
    assign bus.rsp_evict_tag_o = rsp_evict_tag_q;
    assign bus.ls_valid_o      = ls_valid;
    assign bus.ls_op_o         = ls_op;
    assign bus.ls_way_o        = ls_way;

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Self-checking bench for cache_tag_ctrl: a tag/valid array model plus literal expectations.
// Honours CACHE_TAG_CTRL_CHECK_EN the same way the design does.
module tb_cache_tag_ctrl;
    localparam int NUM_WAYS = 4;
    localparam int TAG_W    = 8;
    localparam int WL       = 2;
`ifdef CACHE_TAG_CTRL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cache_tag_ctrl_if #(.NUM_WAYS(NUM_WAYS), .TAG_W(TAG_W)) bus ();

    cache_tag_ctrl #(.NUM_WAYS(NUM_WAYS), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model of the single set: what each way holds according to the request history.
    logic [TAG_W-1:0]    m_tag [NUM_WAYS];
    logic [NUM_WAYS-1:0] m_vld;
    logic                m_err;

    logic             cmp_en;
    logic             e_ready, e_rsp_valid, e_fields_chk, e_tag_known;
    logic             e_hit, e_evict, e_ls_valid, e_err;
    logic [WL-1:0]    e_way, e_ls_way;
    logic [1:0]       e_ls_op;
    logic [TAG_W-1:0] e_etag;

    int               total_pulses;
    logic [1:0]       last_ls_op;
    logic [WL-1:0]    last_ls_way;
    logic             last_hit, last_evict;
    logic [WL-1:0]    last_way;
    logic [TAG_W-1:0] last_etag;
    int               last_pulses;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic compareCycle();
        checkOutput("req_ready", 32'(bus.req_ready_o), 32'(e_ready));
        checkOutput("rsp_valid", 32'(bus.rsp_valid_o), 32'(e_rsp_valid));
        checkOutput("ls_valid", 32'(bus.ls_valid_o), 32'(e_ls_valid));
        checkOutput("ls_op", 32'(bus.ls_op_o), 32'(e_ls_op));
        checkOutput("ls_way", 32'(bus.ls_way_o), 32'(e_ls_way));
        checkOutput("err", 32'(bus.err_o), 32'(e_err));
        if (e_rsp_valid || e_fields_chk) begin
            checkOutput("rsp_hit", 32'(bus.rsp_hit_o), 32'(e_hit));
            checkOutput("rsp_way", 32'(bus.rsp_way_o), 32'(e_way));
            checkOutput("rsp_evict", 32'(bus.rsp_evict_o), 32'(e_evict));
        end
        if (e_tag_known || e_fields_chk)
            checkOutput("rsp_evict_tag", 32'(bus.rsp_evict_tag_o), 32'(e_etag));
        if (bus.ls_valid_o === 1'b1) begin
            total_pulses++;
            last_ls_op  = bus.ls_op_o;
            last_ls_way = bus.ls_way_o;
        end
    endtask

    task automatic setIdleAfterReset();
        e_ready = 1'b1; e_rsp_valid = 1'b0; e_fields_chk = 1'b1; e_tag_known = 1'b0;
        e_hit = 1'b0; e_evict = 1'b0; e_way = '0; e_etag = '0;
        e_ls_valid = 1'b0; e_ls_op = 2'b00; e_ls_way = '0; e_err = 1'b0;
        m_vld = '0; m_err = 1'b0;
        for (int i = 0; i < NUM_WAYS; i++) m_tag[i] = '0;
    endtask

    // Called at posedge+1 while the controller is idle; optionally resets it in RESP after the hold.
    task automatic applyStimulus(input logic [1:0] op, input logic [TAG_W-1:0] tg,
                                 input logic [NUM_WAYS-1:0] lway, input logic lvalid,
                                 input int hold, input bit rst_in_resp);
        int               hi;
        int               p0;
        logic [WL-1:0]    v;
        logic             x_ls_valid, x_hit, x_evict, x_tag_known, x_err;
        logic [1:0]       x_ls_op;
        logic [WL-1:0]    x_ls_way, x_way;
        logic [TAG_W-1:0] x_etag;

        hi = -1;
        for (int i = 0; i < NUM_WAYS; i++) if (m_vld[i] && m_tag[i] == tg) hi = i;
        x_ls_valid = 1'b0; x_ls_op = 2'b00; x_ls_way = '0; x_hit = 1'b0; x_way = '0;
        x_evict = 1'b0; x_etag = '0; x_tag_known = 1'b0; x_err = m_err;
        if (op == 2'b01) begin
            x_ls_valid = 1'b1;
            if (hi >= 0) begin
                x_ls_op = 2'b01; x_ls_way = WL'(hi); x_hit = 1'b1; x_way = WL'(hi);
            end else begin
                x_ls_op = 2'b10;
                v = '0;
                for (int i = NUM_WAYS - 1; i >= 0; i--) if (lway[i]) v = WL'(i);
                x_way = v; x_evict = m_vld[v]; x_etag = m_tag[v]; x_tag_known = 1'b1;
                m_tag[v] = tg; m_vld[v] = 1'b1;
                if (CHK && (!lvalid || $countones(lway) != 1)) x_err = 1'b1;
            end
        end else if (op == 2'b11 && hi >= 0) begin
            x_ls_valid = 1'b1; x_ls_op = 2'b11; x_ls_way = WL'(hi);
            x_hit = 1'b1; x_way = WL'(hi);
            m_vld[hi] = 1'b0;
        end
        m_err = x_err;

        p0 = total_pulses;
        bus.req_valid_i = 1'b1; bus.req_op_i = op; bus.req_tag_i = tg;
        e_ready = 1'b1; e_rsp_valid = 1'b0; e_fields_chk = 1'b0; e_tag_known = 1'b0;
        e_ls_valid = 1'b0; e_ls_op = 2'b00; e_ls_way = '0;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0; bus.lru_way_i = lway; bus.lru_valid_i = lvalid;
        e_ready = 1'b0; e_ls_valid = x_ls_valid; e_ls_op = x_ls_op; e_ls_way = x_ls_way;
        @(posedge clk); #1;
        bus.lru_way_i = '0; bus.lru_valid_i = 1'b0; bus.rsp_ready_i = 1'b0;
        e_ls_valid = 1'b0; e_ls_op = 2'b00; e_ls_way = '0; e_rsp_valid = 1'b1;
        e_hit = x_hit; e_way = x_way; e_evict = x_evict; e_etag = x_etag;
        e_tag_known = x_tag_known; e_err = x_err;
        @(negedge clk);
        last_hit = bus.rsp_hit_o; last_way = bus.rsp_way_o;
        last_evict = bus.rsp_evict_o; last_etag = bus.rsp_evict_tag_o;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
        end
        last_pulses = total_pulses - p0;
        if (rst_in_resp) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            setIdleAfterReset();
        end else begin
            bus.rsp_ready_i = 1'b1;
            @(posedge clk); #1;
            bus.rsp_ready_i = 1'b0;
            e_ready = 1'b1; e_rsp_valid = 1'b0; e_tag_known = 1'b0;
        end
    endtask

    task automatic checkTxn(input string nm, input logic hit, input logic [WL-1:0] way,
                            input logic evict, input int pulses);
        checkOutput({nm, "_hit"}, 32'(last_hit), 32'(hit));
        checkOutput({nm, "_way"}, 32'(last_way), 32'(way));
        checkOutput({nm, "_evict"}, 32'(last_evict), 32'(evict));
        checkOutput({nm, "_pulses"}, 32'(last_pulses), 32'(pulses));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        cmp_en = 1'b0; total_pulses = 0;
        last_ls_op = 2'b00; last_ls_way = '0; last_pulses = 0;
        reset = 1'b1;
        bus.req_valid_i = 1'b0; bus.req_op_i = 2'b00; bus.req_tag_i = '0;
        bus.rsp_ready_i = 1'b0; bus.lru_valid_i = 1'b0; bus.lru_way_i = '0;
        setIdleAfterReset();

        fork
            forever begin
                @(negedge clk);
                if (cmp_en) compareCycle();
            end
        join_none

        repeat (2) @(posedge clk);
        #1 cmp_en = 1'b1;
        @(negedge clk);
        checkOutput("rst_req_ready", 32'(bus.req_ready_o), 32'd1);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        checkOutput("rst_ls_valid", 32'(bus.ls_valid_o), 32'd0);
        checkOutput("rst_err", 32'(bus.err_o), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        applyStimulus(2'b01, 8'h11, 4'b0001, 1'b1, 0, 1'b0);
        checkTxn("fill0", 1'b0, 2'd0, 1'b0, 1);
        checkOutput("fill0_ls_op", 32'(last_ls_op), 32'h2);
        applyStimulus(2'b01, 8'h22, 4'b0010, 1'b1, 0, 1'b0);
        checkTxn("fill1", 1'b0, 2'd1, 1'b0, 1);
        applyStimulus(2'b01, 8'h33, 4'b0100, 1'b1, 1, 1'b0);
        checkTxn("fill2", 1'b0, 2'd2, 1'b0, 1);
        applyStimulus(2'b01, 8'h44, 4'b1000, 1'b1, 0, 1'b0);
        checkTxn("fill3", 1'b0, 2'd3, 1'b0, 1);

        applyStimulus(2'b01, 8'h22, 4'b0001, 1'b1, 0, 1'b0);
        checkTxn("hit22", 1'b1, 2'd1, 1'b0, 1);
        checkOutput("hit22_ls_op", 32'(last_ls_op), 32'h1);
        checkOutput("hit22_ls_way", 32'(last_ls_way), 32'd1);

        applyStimulus(2'b01, 8'h55, 4'b0001, 1'b1, 0, 1'b0);
        checkTxn("evict55", 1'b0, 2'd0, 1'b1, 1);
        checkOutput("evict55_tag", 32'(last_etag), 32'h11);
        applyStimulus(2'b01, 8'h11, 4'b0010, 1'b1, 0, 1'b0);
        checkTxn("refill11", 1'b0, 2'd1, 1'b1, 1);
        checkOutput("refill11_tag", 32'(last_etag), 32'h22);

        applyStimulus(2'b11, 8'h33, 4'b0000, 1'b0, 0, 1'b0);
        checkTxn("inv33", 1'b1, 2'd2, 1'b0, 1);
        checkOutput("inv33_ls_op", 32'(last_ls_op), 32'h3);
        checkOutput("inv33_ls_way", 32'(last_ls_way), 32'd2);
        applyStimulus(2'b01, 8'h66, 4'b0100, 1'b1, 0, 1'b0);
        checkTxn("fill66", 1'b0, 2'd2, 1'b0, 1);
        applyStimulus(2'b11, 8'h99, 4'b0000, 1'b0, 0, 1'b0);
        checkTxn("inv99", 1'b0, 2'd0, 1'b0, 0);

        applyStimulus(2'b00, 8'h55, 4'b0001, 1'b1, 0, 1'b0);
        checkTxn("op00", 1'b0, 2'd0, 1'b0, 0);
        applyStimulus(2'b10, 8'h66, 4'b0001, 1'b1, 0, 1'b0);
        checkTxn("op10", 1'b0, 2'd0, 1'b0, 0);

        applyStimulus(2'b01, 8'h88, 4'b0000, 1'b0, 0, 1'b0);
        checkTxn("bad_lru", 1'b0, 2'd0, 1'b1, 1);
        checkOutput("bad_lru_err", 32'(bus.err_o), 32'(CHK));
        applyStimulus(2'b01, 8'h77, 4'b0110, 1'b1, 0, 1'b0);
        checkTxn("multi_lru", 1'b0, 2'd1, 1'b1, 1);
        applyStimulus(2'b01, 8'h77, 4'b0001, 1'b1, 0, 1'b0);
        checkTxn("hit77", 1'b1, 2'd1, 1'b0, 1);
        checkOutput("err_sticky", 32'(bus.err_o), 32'(CHK));

        applyStimulus(2'b01, 8'h44, 4'b0001, 1'b1, 5, 1'b1);
        checkTxn("bp44", 1'b1, 2'd3, 1'b0, 1);
        @(negedge clk);
        checkOutput("post_rst_ready", 32'(bus.req_ready_o), 32'd1);
        checkOutput("post_rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        checkOutput("post_rst_err", 32'(bus.err_o), 32'd0);
        @(posedge clk); #1;

        applyStimulus(2'b01, 8'h22, 4'b0001, 1'b1, 0, 1'b0);
        checkTxn("after_rst22", 1'b0, 2'd0, 1'b0, 1);

        repeat (2) @(posedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cache_tag_ctrl.md
# cache_tag_ctrl

Single-set tag controller that drives the LRU tracker's load/store/invalidate interface. It accepts lookup and invalidate requests by tag and compares them against NUM_WAYS tag registers. It reports hits to the LRU as loads, allocates misses as stores using the LRU's returned victim way, and forwards invalidates. It sits between the load/store pipeline and the `lru` block, and keeps its own per-way valid bits in lock-step with the LRU's availability state.

## Interface
- NUM_WAYS, 4, number of ways; power of two, ≥2
- TAG_W, 8, tag width in bits
- WL: localparam, $clog2(NUM_WAYS)

Clocking and reset:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; must be asserted in the same cycles as the LRU's reset

Request channel:
- req_valid_i  in  1  request present
- req_ready_o  out  1  controller can accept
- req_op_i  in  2  01 = lookup, 11 = invalidate; 00 and 10 are accepted and answered as a miss with no LRU op
- req_tag_i  in  TAG_W  request tag

Response channel:
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  consumer accepts the response
- rsp_hit_o  out  1  tag matched a valid way
- rsp_way_o  out  WL  hit way, or way allocated on a miss
- rsp_evict_o  out  1  the allocation replaced a valid line
- rsp_evict_tag_o  out  TAG_W  tag of the replaced line

LRU interface:
- ls_valid_o  out  1  LRU operation strobe
- ls_op_o  out  2  01 load, 10 store, 11 invalidate
- ls_way_o  out  WL  way index for load/invalidate; 0 for store
- lru_valid_i  in  1  LRU victim valid (combinational response to the store)
- lru_way_i  in  NUM_WAYS  one-hot victim way

Error:
- err_o  out  1  sticky protocol error; see Configuration

## Operation
- State is held in tag[NUM_WAYS], vld[NUM_WAYS], the latched request (op, tag), and a 3-state FSM: IDLE, CMP, RESP.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i & req_ready_o: latch op and tag, go to CMP.
- CMP lasts exactly one cycle.
  - hit = vld[w] & (tag[w] == latched tag). At most one way can hit; tags are kept unique because a fill only happens on a miss.
  - Lookup hit: ls_valid_o=1, ls_op_o=01, ls_way_o=hit way. Response: hit=1, way=hit way, evict=0.
  - Lookup miss: ls_valid_o=1, ls_op_o=10, ls_way_o=0.
    - Victim v = index of the lowest set bit of lru_way_i, sampled in this same cycle.
    - evict = vld[v]; evict_tag = tag[v].
    - Then tag[v] <= latched tag and vld[v] <= 1.
    - Response: hit=0, way=v.
  - Invalidate hit: ls_valid_o=1, ls_op_o=11, ls_way_o=hit way; vld[hit way] <= 0. Response: hit=1, way=hit way.
  - Invalidate miss: ls_valid_o=0. Response: hit=0, way=0, evict=0.
  - CMP always goes to RESP.
- RESP:
  - rsp_valid_o=1; all rsp_* fields registered and held stable.
  - On rsp_ready_i, go to IDLE.
- Outside CMP, ls_valid_o, ls_op_o and ls_way_o are 0.
- Invariant: after every CMP, the LRU's way-available bit for each way equals ~vld for that way.

## Timing
- Request handshake in cycle T:
  - CMP and the ls strobe occur in T+1.
  - rsp_valid_o rises in T+2.
- ls_valid_o is high for exactly one cycle per request, and never for an invalidate miss or an unsupported op.
- req_ready_o is low in CMP and RESP. The earliest next acceptance is the cycle after the response handshake, giving a minimum of 3 cycles per request.
- rsp_valid_o, once high, stays high with stable fields until rsp_ready_i is sampled high.
- Reset values:
  - State: state=IDLE, all vld=0, tag=0, err_o=0.
  - Outputs: req_ready_o=1, rsp_valid_o=0, rsp_hit_o=0, rsp_way_o=0, rsp_evict_o=0, rsp_evict_tag_o=0, ls_valid_o=0, ls_op_o=0, ls_way_o=0.
- Reset asserted mid-operation (CMP or RESP) abandons the request: no response is issued and all vld are cleared in the same edge.

## Configuration
- Macro CACHE_TAG_CTRL_CHECK_EN.
- Defined: in a lookup-miss CMP cycle, err_o is set if lru_valid_i==0 or lru_way_i is not exactly one-hot. err_o stays set until reset. The victim falls back to way 0 when lru_way_i==0; otherwise it is the lowest set bit as normal.
- Not defined: err_o is tied to 0 and no checking logic is built. Victim selection is unchanged: lowest set bit, or way 0 if none.

## Test plan
- Fill: after reset, look up 0x11, 0x22, 0x33, 0x44 with lru_way_i = 0001, 0010, 0100, 1000 in turn → each issues ls_op 10, and responses are hit=0, way=0/1/2/3, evict=0.
- Hit: then look up 0x22 → ls_op 01, ls_way 1, one-cycle strobe; rsp_valid at T+2 with hit=1, way=1.
- Eviction: then look up 0x55 with lru_way_i=0001 → rsp way=0, evict=1, evict_tag=0x11. A following lookup of 0x11 misses.
- Invalidate: invalidate 0x33 → ls_op 11, ls_way 2, hit=1. Next, look up 0x66 with lru_way_i=0100 → way=2, evict=0. Invalidate 0x99 → no ls_valid, hit=0.
- Backpressure/reset: hold rsp_ready_i=0 for 5 cycles → rsp fields stable and req_ready_o=0. Assert reset in RESP → rsp_valid_o=0 and req_ready_o=1 next cycle. A lookup of 0x22 afterwards misses.
- Check macro: during a miss drive lru_valid_i=0 and lru_way_i=0000 → with the macro, err_o=1 from the next cycle and stays 1, way=0. Without the macro, err_o stays 0 and way=0.
